// File: rtl/hdmi_tmds_period_sequencer.sv
// HDMI channel back end: delays the pixel/sync/packet stream, inserts preambles
// and guard bands from lookahead history, and encodes each slot into three TMDS symbols.
module hdmi_tmds_period_sequencer #(
   parameter int unsigned PRE_LEN = 8,
   parameter int unsigned GB_LEN  = 2
) (
   input  logic       i_pixclk,
   input  logic       i_resetn,
   input  logic [7:0] i_red,
   input  logic [7:0] i_green,
   input  logic       i_blank,
   input  logic [7:0] i_blue,
   input  logic       i_hSync,
   input  logic       i_vSync,
   input  logic [3:0] i_d0,
   input  logic [3:0] i_d1,
   input  logic [3:0] i_d2,
   input  logic       i_data,
   output logic [9:0] o_tmds0,
   output logic [9:0] o_tmds1,
   output logic [9:0] o_tmds2,
   output logic       o_err
);
   localparam int unsigned LOOK  = PRE_LEN + GB_LEN;
   localparam int unsigned DEPTH = LOOK + 1;
   localparam logic [9:0]  CTL00 = 10'b1101010100;
   localparam logic [9:0]  GB_A  = 10'b1011001100;
   localparam logic [9:0]  GB_B  = 10'b0100110011;

   typedef struct packed {
      logic       blank;
      logic       data;
      logic       hsync;
      logic       vsync;
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
      logic [3:0] d0;
      logic [3:0] d1;
      logic [3:0] d2;
   } slot_t;

   localparam slot_t IDLE = '{blank: 1'b1, data: 1'b0, hsync: 1'b0, vsync: 1'b0,
                              red: '0, green: '0, blue: '0, d0: '0, d1: '0, d2: '0};

   typedef enum logic [2:0] {
      P_CTRL, P_VID_PRE, P_VID_GB, P_DI_PRE, P_DI_GB, P_DATA, P_VIDEO
   } period_t;

   slot_t             in_q;
   slot_t             hist [DEPTH];
   slot_t             cur;
   logic [GB_LEN-1:0] past_data;
   logic [4:0]        disp      [3];
   logic [4:0]        disp_next [3];
   logic [9:0]        sym_next  [3];
   logic              di_gb, di_pre, vid_gb, vid_pre, insert, err_hit;
   period_t           period;

   function automatic logic [9:0] ctrl_tok(input logic [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   function automatic logic [9:0] terc4(input logic [3:0] d);
      case (d)
         4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
         4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
         4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
         4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
         4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
         4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
         4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
         4'hE: return 10'b0101100011;  default: return 10'b1011000011;
      endcase
   endfunction

   // Returns {next disparity, symbol} for one DVI 8b/10b video word.
   function automatic logic [14:0] tmds8(input logic [7:0] d, input logic [4:0] cnt);
      int         n1d, n1q, c, c_new;
      logic       use_xnor;
      logic [8:0] qm;
      logic [9:0] sym;
      n1d = 0;
      n1q = 0;
      for (int unsigned i = 0; i < 8; i++) if (d[i]) n1d++;
      use_xnor = (n1d > 4) || (n1d == 4 && !d[0]);
      qm[0] = d[0];
      for (int unsigned i = 1; i < 8; i++)
         qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~use_xnor;
      for (int unsigned i = 0; i < 8; i++) if (qm[i]) n1q++;
      c = int'($signed(cnt));
      if (c == 0 || n1q == 4) begin
         sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         c_new = qm[8] ? c + 2 * n1q - 8 : c + 8 - 2 * n1q;
      end else if ((c > 0 && n1q > 4) || (c < 0 && n1q < 4)) begin
         sym   = {1'b1, qm[8], ~qm[7:0]};
         c_new = c + (qm[8] ? 2 : 0) + 8 - 2 * n1q;
      end else begin
         sym   = {1'b0, qm[8], qm[7:0]};
         c_new = c - (qm[8] ? 0 : 2) + 2 * n1q - 8;
      end
      return {c_new[4:0], sym};
   endfunction

   assign cur = hist[DEPTH-1];

   // hist[DEPTH-1] is the slot being encoded; hist[DEPTH-1-i] is i slots ahead of it.
   always_comb begin
      di_gb   = 1'b0;
      di_pre  = 1'b0;
      vid_gb  = 1'b0;
      vid_pre = 1'b0;
      for (int unsigned i = 1; i <= LOOK; i++) begin
         if (i <= GB_LEN) begin
            di_gb  = di_gb  | (hist[DEPTH-1-i].data & ~hist[DEPTH-i].data & hist[DEPTH-1-i].blank);
            vid_gb = vid_gb | (~hist[DEPTH-1-i].blank & hist[DEPTH-i].blank);
         end else begin
            di_pre  = di_pre  | (hist[DEPTH-1-i].data & ~hist[DEPTH-i].data & hist[DEPTH-1-i].blank);
            vid_pre = vid_pre | (~hist[DEPTH-1-i].blank & hist[DEPTH-i].blank);
         end
      end
      di_gb  = di_gb | (~cur.data & (|past_data));
      insert = di_gb | di_pre | vid_gb | vid_pre;
      if (!cur.blank)   period = P_VIDEO;
      else if (cur.data) period = P_DATA;
      else if (di_gb)   period = P_DI_GB;
      else if (di_pre)  period = P_DI_PRE;
      else if (vid_gb)  period = P_VID_GB;
      else if (vid_pre) period = P_VID_PRE;
      else              period = P_CTRL;
      err_hit = (((period == P_VIDEO) || (period == P_DATA)) && insert) || (cur.data && !cur.blank);
   end

   always_comb begin
      sym_next[0]  = ctrl_tok({cur.vsync, cur.hsync});
      sym_next[1]  = CTL00;
      sym_next[2]  = CTL00;
      disp_next[0] = '0;
      disp_next[1] = '0;
      disp_next[2] = '0;
      unique case (period)
         P_VIDEO: begin
            {disp_next[2], sym_next[2]} = tmds8(cur.red,   disp[2]);
            {disp_next[1], sym_next[1]} = tmds8(cur.green, disp[1]);
            {disp_next[0], sym_next[0]} = tmds8(cur.blue,  disp[0]);
         end
         P_DATA: begin
            sym_next[0] = terc4(cur.d0);
            sym_next[1] = terc4(cur.d1);
            sym_next[2] = terc4(cur.d2);
         end
         P_DI_GB: begin
            sym_next[0] = terc4({2'b11, cur.vsync, cur.hsync});
            sym_next[1] = GB_B;
            sym_next[2] = GB_B;
         end
         P_DI_PRE: begin
            sym_next[1] = ctrl_tok(2'b01);
            sym_next[2] = ctrl_tok(2'b01);
         end
         P_VID_GB: begin
            sym_next[0] = GB_A;
            sym_next[1] = GB_B;
            sym_next[2] = GB_A;
         end
         P_VID_PRE: sym_next[1] = ctrl_tok(2'b01);
         default: ;
      endcase
   end

   always_ff @(posedge i_pixclk or negedge i_resetn) begin
      if (!i_resetn) begin
         in_q <= IDLE;
         for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= IDLE;
         past_data <= '0;
         for (int unsigned i = 0; i < 3; i++) disp[i] <= '0;
         o_tmds0 <= CTL00;
         o_tmds1 <= CTL00;
         o_tmds2 <= CTL00;
         o_err   <= 1'b0;
      end else begin
         in_q <= '{blank: i_blank, data: i_data, hsync: i_hSync, vsync: i_vSync,
                   red: i_red, green: i_green, blue: i_blue, d0: i_d0, d1: i_d1, d2: i_d2};
         hist[0] <= in_q;
         for (int unsigned i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
         past_data[0] <= cur.data;
         for (int unsigned i = 1; i < GB_LEN; i++) past_data[i] <= past_data[i-1];
         for (int unsigned i = 0; i < 3; i++) disp[i] <= disp_next[i];
         o_tmds0 <= sym_next[0];
         o_tmds1 <= sym_next[1];
         o_tmds2 <= sym_next[2];
         o_err   <= o_err | err_hit;
      end
   end
endmodule

// File: tb/tb_hdmi_tmds_period_sequencer.sv
// Bench for hdmi_tmds_period_sequencer: directed and random line segments checked
// every cycle against a slot-level reference model of the period rules.
module tb_hdmi_tmds_period_sequencer;
   localparam int MAXC = 8192;
   localparam int LAT  = 12;
   localparam int PRE  = 8;
   localparam int GB   = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] red = '0, green = '0, blue = '0;
   logic       blank = 1'b1, hsync = 1'b0, vsync = 1'b0, data = 1'b0;
   logic [3:0] d0 = '0, d1 = '0, d2 = '0;
   logic [9:0] tmds0, tmds1, tmds2;
   logic       err;

   hdmi_tmds_period_sequencer #(.PRE_LEN(8), .GB_LEN(2)) dut (
      .i_pixclk(clk), .i_resetn(rst_n), .i_red(red), .i_green(green), .i_blank(blank),
      .i_blue(blue), .i_hSync(hsync), .i_vSync(vsync), .i_d0(d0), .i_d1(d1), .i_d2(d2),
      .i_data(data), .o_tmds0(tmds0), .o_tmds1(tmds1), .o_tmds2(tmds2), .o_err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit blank; bit data; bit hs; bit vs;
      bit [7:0] r; bit [7:0] g; bit [7:0] b;
      bit [3:0] d0; bit [3:0] d1; bit [3:0] d2;
   } in_t;

   typedef struct { int edge_n; int ch; logic [9:0] val; } spot_t;

   in_t   s [MAXC];
   spot_t spots [$];
   int    cyc = 0, epoch = -1, n_total = 0, n_bad = 0;
   int    md [3];
   bit    merr;

   task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%b want=%b", tag, got, want);
      end
   endtask

   function automatic in_t blank_slot(bit hs, bit vs);
      in_t v;
      v.blank = 1'b1; v.data = 1'b0; v.hs = hs; v.vs = vs;
      v.r = '0; v.g = '0; v.b = '0; v.d0 = '0; v.d1 = '0; v.d2 = '0;
      return v;
   endfunction

   function automatic in_t video_slot(bit [7:0] r, bit [7:0] g, bit [7:0] b);
      in_t v;
      v = blank_slot(1'b0, 1'b0);
      v.blank = 1'b0; v.r = r; v.g = g; v.b = b;
      return v;
   endfunction

   function automatic in_t island_slot(bit hs, bit vs);
      in_t v;
      v = blank_slot(hs, vs);
      v.data = 1'b1; v.d0 = 4'($urandom); v.d1 = 4'($urandom); v.d2 = 4'($urandom);
      return v;
   endfunction

   function automatic in_t S(int idx);
      if (idx < 0) return blank_slot(1'b0, 1'b0);
      return s[idx];
   endfunction

   function automatic logic [9:0] ctrl_sym(bit [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   function automatic logic [9:0] terc4_sym(bit [3:0] d);
      case (d)
         4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
         4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
         4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
         4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
         4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
         4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
         4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
         4'hE: return 10'b0101100011;  default: return 10'b1011000011;
      endcase
   endfunction

   // Running disparity tracked as ones-minus-zeros of every transmitted symbol.
   function automatic logic [9:0] tmds_ref(bit [7:0] d, int ch);
      bit [7:0]   q;
      bit         q8, inv;
      int         ones, bal;
      logic [9:0] sym;
      ones = $countones(d);
      q8 = !(ones > 4 || (ones == 4 && !d[0]));
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = q8 ? (q[i-1] ^ d[i]) : !(q[i-1] ^ d[i]);
      bal = 2 * $countones(q) - 8;
      inv = (md[ch] == 0 || bal == 0) ? !q8 : ((md[ch] > 0) == (bal > 0));
      sym = {inv, q8, inv ? ~q : q};
      md[ch] += 2 * $countones(sym) - 10;
      return sym;
   endfunction

   task automatic model_edge(input int c, output logic [9:0] e0, output logic [9:0] e1,
                             output logic [9:0] e2, output bit ee);
      int  k;
      in_t cur;
      bit  dgb, dpre, vgb, vpre, ins;
      k = c - LAT;
      cur = S(k);
      dgb = 0; dpre = 0; vgb = 0; vpre = 0;
      for (int i = 1; i <= PRE + GB; i++) begin
         in_t a, p;
         a = S(k + i);
         p = S(k + i - 1);
         if (a.data && !p.data && a.blank) begin if (i <= GB) dgb = 1; else dpre = 1; end
         if (!a.blank && p.blank)          begin if (i <= GB) vgb = 1; else vpre = 1; end
      end
      for (int i = 1; i <= GB; i++) if (!cur.data && S(k - i).data) dgb = 1;
      ins = dgb || dpre || vgb || vpre;
      e0 = ctrl_sym({cur.vs, cur.hs});
      e1 = ctrl_sym(2'b00);
      e2 = e1;
      if (!cur.blank) begin
         e2 = tmds_ref(cur.r, 2);
         e1 = tmds_ref(cur.g, 1);
         e0 = tmds_ref(cur.b, 0);
         if (ins || cur.data) merr = 1;
      end else begin
         md[0] = 0; md[1] = 0; md[2] = 0;
         if (cur.data) begin
            e0 = terc4_sym(cur.d0); e1 = terc4_sym(cur.d1); e2 = terc4_sym(cur.d2);
            if (ins) merr = 1;
         end else if (dgb) begin
            e0 = terc4_sym({2'b11, cur.vs, cur.hs}); e1 = 10'b0100110011; e2 = e1;
         end else if (dpre) begin
            e1 = ctrl_sym(2'b01); e2 = e1;
         end else if (vgb) begin
            e0 = 10'b1011001100; e1 = 10'b0100110011; e2 = 10'b1011001100;
         end else if (vpre) begin
            e1 = ctrl_sym(2'b01);
         end
      end
      ee = merr;
   endtask

   function automatic logic [9:0] observed(int ch);
      case (ch)
         0:       return tmds0;
         1:       return tmds1;
         2:       return tmds2;
         default: return {9'b0, err};
      endcase
   endfunction

   task automatic tick(input in_t v);
      logic [9:0] e0, e1, e2;
      bit         ee;
      red = v.r; green = v.g; blue = v.b; blank = v.blank; data = v.data;
      hsync = v.hs; vsync = v.vs; d0 = v.d0; d1 = v.d1; d2 = v.d2;
      s[cyc] = v;
      @(posedge clk);
      #1;
      model_edge(cyc, e0, e1, e2, ee);
      check($sformatf("ch0@%0d/%0d", epoch, cyc), tmds0, e0);
      check($sformatf("ch1@%0d/%0d", epoch, cyc), tmds1, e1);
      check($sformatf("ch2@%0d/%0d", epoch, cyc), tmds2, e2);
      check($sformatf("err@%0d/%0d", epoch, cyc), {9'b0, err}, {9'b0, ee});
      if (epoch == 0)
         foreach (spots[i])
            if (spots[i].edge_n == cyc)
               check($sformatf("spot_ch%0d@%0d", spots[i].ch, cyc), observed(spots[i].ch), spots[i].val);
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_async_ch0", tmds0, 10'b1101010100);
      check("rst_async_ch1", tmds1, 10'b1101010100);
      check("rst_async_ch2", tmds2, 10'b1101010100);
      check("rst_async_err", {9'b0, err}, 10'd0);
      @(posedge clk);
      #1;
      check("rst_edge_ch0", tmds0, 10'b1101010100);
      check("rst_edge_ch2", tmds2, 10'b1101010100);
      check("rst_edge_err", {9'b0, err}, 10'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      epoch++;
      md[0] = 0; md[1] = 0; md[2] = 0;
      merr = 0;
   endtask

   task automatic rand_segments(input int nseg, input bit tidy);
      for (int sg = 0; sg < nseg && cyc < MAXC - 200; sg++) begin
         int kind;
         bit hs, vs;
         kind = int'($urandom_range(0, 2));
         hs = 1'($urandom);
         vs = 1'($urandom);
         if (tidy && kind != 0) repeat (12) tick(blank_slot(hs, vs));
         case (kind)
            0:       repeat ($urandom_range(1, 40)) tick(blank_slot(hs, vs));
            1:       repeat ($urandom_range(1, 32)) tick(island_slot(hs, vs));
            default: repeat ($urandom_range(1, 60))
                        tick(video_slot(8'($urandom), 8'($urandom), 8'($urandom)));
         endcase
         if (tidy && kind != 0) repeat (12) tick(blank_slot(hs, vs));
      end
   endtask

   initial begin
      spots.push_back('{20,  0, 10'b0010101011});
      spots.push_back('{20,  1, 10'b1101010100});
      spots.push_back('{20,  3, 10'd0});
      spots.push_back('{102, 1, 10'b0010101011});
      spots.push_back('{102, 2, 10'b1101010100});
      spots.push_back('{109, 1, 10'b0010101011});
      spots.push_back('{110, 0, 10'b1011001100});
      spots.push_back('{110, 1, 10'b0100110011});
      spots.push_back('{111, 2, 10'b1011001100});
      spots.push_back('{112, 0, 10'b0100000000});
      spots.push_back('{202, 1, 10'b0010101011});
      spots.push_back('{202, 2, 10'b0010101011});
      spots.push_back('{209, 2, 10'b0010101011});
      spots.push_back('{210, 1, 10'b0100110011});
      spots.push_back('{245, 1, 10'b0100110011});
      spots.push_back('{246, 1, 10'b1101010100});
      spots.push_back('{440, 3, 10'd0});
      spots.push_back('{460, 3, 10'd1});

      #2;
      do_reset();
      for (int n = 0;   n < 100; n++) tick(blank_slot(1'b1, 1'b0));
      for (int n = 100; n < 120; n++) tick(video_slot(8'h00, 8'h00, 8'h00));
      for (int n = 120; n < 200; n++) tick(blank_slot(1'b1, 1'b0));
      for (int n = 200; n < 232; n++) tick(island_slot(1'b1, 1'b0));
      for (int n = 232; n < 300; n++) tick(blank_slot(1'b1, 1'b0));
      for (int n = 300; n < 364; n++) tick(video_slot(8'hFF, 8'hFF, 8'hFF));
      for (int n = 364; n < 400; n++) tick(blank_slot(1'b0, 1'b1));
      for (int n = 400; n < 450; n++) tick(video_slot(8'($urandom), 8'($urandom), 8'($urandom)));
      for (int n = 450; n < 454; n++) tick(blank_slot(1'b1, 1'b1));
      for (int n = 454; n < 462; n++) tick(island_slot(1'b1, 1'b1));
      for (int n = 462; n < 546; n++) tick(blank_slot(1'b0, 1'b0));
      for (int n = 546; n < 566; n++) tick(island_slot(1'b1, 1'b0));
      do_reset();
      repeat (40) tick(blank_slot(1'b1, 1'b0));
      rand_segments(50, 1'b1);
      do_reset();
      rand_segments(60, 1'b0);
      repeat (20) tick(blank_slot(1'b0, 1'b0));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
